// File: rtl/pippo_alu_issue_if.sv
// Decode -> issue -> ALU -> writeback signal bundle for pippo_alu_issue.
// slave is the issue unit side, master the decode/ALU/writeback side.
`ifndef OPERAND_WIDTH
`define OPERAND_WIDTH 64
`endif
`ifndef ALUUOPS_WIDTH
`define ALUUOPS_WIDTH 8
`endif

interface pippo_alu_issue_if #(
  parameter int width  = `OPERAND_WIDTH,
  parameter int uops_w = `ALUUOPS_WIDTH
);
  logic              id_valid;
  logic              id_ready;
  logic [uops_w-1:0] id_uops;
  logic [width-1:0]  id_opa;
  logic [width-1:0]  id_opb;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [4:0]        id_rd;
  logic              flush;
  logic [uops_w-1:0] alu_uops;
  logic [width-1:0]  bus_a;
  logic [width-1:0]  bus_b;
  logic [width-1:0]  alu_result;
  logic              wb_valid;
  logic              wb_ready;
  logic [width-1:0]  wb_result;
  logic [4:0]        wb_rd;
  logic              busy;

  modport master (
    output id_valid, id_uops, id_opa, id_opb, id_rs1, id_rs2,
           id_use_rs1, id_use_rs2, id_rd, flush, alu_result, wb_ready,
    input  id_ready, alu_uops, bus_a, bus_b, wb_valid, wb_result, wb_rd, busy
  );

  modport slave (
    input  id_valid, id_uops, id_opa, id_opb, id_rs1, id_rs2,
           id_use_rs1, id_use_rs2, id_rd, flush, alu_result, wb_ready,
    output id_ready, alu_uops, bus_a, bus_b, wb_valid, wb_result, wb_rd, busy
  );
endinterface

// File: rtl/pippo_alu_issue.sv
// 2-entry ALU issue queue feeding a combinational ALU with a registered writeback stage.
// Define PIPPO_ALU_FWD_EN to forward the last issued result onto bus_a/bus_b.
`ifndef OPERAND_WIDTH
`define OPERAND_WIDTH 64
`endif
`ifndef ALUUOPS_WIDTH
`define ALUUOPS_WIDTH 8
`endif

module pippo_alu_issue #(
  parameter int width  = `OPERAND_WIDTH,
  parameter int uops_w = `ALUUOPS_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  pippo_alu_issue_if.slave io
);

  typedef struct packed {
    logic [uops_w-1:0] uops;
    logic [width-1:0]  opa;
    logic [width-1:0]  opb;
`ifdef PIPPO_ALU_FWD_EN
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic              use_rs1;
    logic              use_rs2;
`endif
    logic [4:0]        rd;
  } entry_t;

  entry_t            fifo_q [2];
  entry_t            head;
  entry_t            id_ent;
  logic [1:0]        count_q, count_d;
  logic              wptr_q, rptr_q;
  logic              push, issue;
  logic              wb_valid_q;
  logic [width-1:0]  wb_result_q;
  logic [4:0]        wb_rd_q;
  logic [width-1:0]  hold_a_q, hold_b_q;
  logic [width-1:0]  bus_a_d, bus_b_d;
  logic [uops_w-1:0] alu_uops_d;

  assign head  = fifo_q[rptr_q];
  assign push  = io.id_valid && io.id_ready;
  assign issue = (count_q != 2'd0) && (!wb_valid_q || io.wb_ready);

  always_comb begin
    id_ent         = '0;
    id_ent.uops    = io.id_uops;
    id_ent.opa     = io.id_opa;
    id_ent.opb     = io.id_opb;
    id_ent.rd      = io.id_rd;
`ifdef PIPPO_ALU_FWD_EN
    id_ent.rs1     = io.id_rs1;
    id_ent.rs2     = io.id_rs2;
    id_ent.use_rs1 = io.id_use_rs1;
    id_ent.use_rs2 = io.id_use_rs2;
`endif
  end

  always_comb begin
    count_d = count_q;
    case ({push, issue})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

`ifdef PIPPO_ALU_FWD_EN
  logic             fwd_vld_q;
  logic [4:0]       fwd_rd_q;
  logic [width-1:0] fwd_data_q;

  // fwd_data mirrors the result just captured at issue; x0 never forwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_vld_q  <= 1'b0;
      fwd_rd_q   <= '0;
      fwd_data_q <= '0;
    end else if (io.flush) begin
      fwd_vld_q  <= 1'b0;
    end else if (issue) begin
      fwd_vld_q  <= 1'b1;
      fwd_rd_q   <= head.rd;
      fwd_data_q <= io.alu_result;
    end
  end
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{io.id_rs1, io.id_rs2, io.id_use_rs1, io.id_use_rs2};
`endif

  // Empty queue: uops idle at 0, operand buses park on the last head values.
  always_comb begin
    alu_uops_d = '0;
    bus_a_d    = hold_a_q;
    bus_b_d    = hold_b_q;
    if (count_q != 2'd0) begin
      alu_uops_d = head.uops;
      bus_a_d    = head.opa;
      bus_b_d    = head.opb;
`ifdef PIPPO_ALU_FWD_EN
      if (head.use_rs1 && fwd_vld_q && (head.rs1 == fwd_rd_q) && (head.rs1 != 5'd0))
        bus_a_d = fwd_data_q;
      if (head.use_rs2 && fwd_vld_q && (head.rs2 == fwd_rd_q) && (head.rs2 != 5'd0))
        bus_b_d = fwd_data_q;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 2'd0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
    end else if (io.flush) begin
      count_q <= 2'd0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push)  wptr_q <= ~wptr_q;
      if (issue) rptr_q <= ~rptr_q;
    end
  end

  // Payload storage needs no reset; count_q qualifies every read.
  always_ff @(posedge clk) begin
    if (push && !io.flush && !rst)
      fifo_q[wptr_q] <= id_ent;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_a_q <= '0;
      hold_b_q <= '0;
    end else if (count_q != 2'd0) begin
      hold_a_q <= bus_a_d;
      hold_b_q <= bus_b_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q  <= 1'b0;
      wb_result_q <= '0;
      wb_rd_q     <= '0;
    end else if (io.flush) begin
      wb_valid_q  <= 1'b0;
    end else if (issue) begin
      wb_valid_q  <= 1'b1;
      wb_result_q <= io.alu_result;
      wb_rd_q     <= head.rd;
    end else if (io.wb_ready) begin
      wb_valid_q  <= 1'b0;
    end
  end

  assign io.id_ready  = (count_q != 2'd2);
  assign io.alu_uops  = alu_uops_d;
  assign io.bus_a     = bus_a_d;
  assign io.bus_b     = bus_b_d;
  assign io.wb_valid  = wb_valid_q;
  assign io.wb_result = wb_result_q;
  assign io.wb_rd     = wb_rd_q;
  assign io.busy      = (count_q != 2'd0) | wb_valid_q;

endmodule

// File: tb/tb_pippo_alu_issue.sv
// Scoreboard bench for pippo_alu_issue: a reference ALU model computes each op's
// result at push time; the writeback monitor pops and compares in order.
module tb_pippo_alu_issue;
  localparam int W  = 64;
  localparam int UW = 8;
  localparam logic [UW-1:0] OP_ADD = 8'd1;
  localparam logic [UW-1:0] OP_SUB = 8'd2;
  localparam logic [UW-1:0] OP_XOR = 8'd3;
`ifdef PIPPO_ALU_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]   rd;
    logic [W-1:0] res;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pippo_alu_issue_if #(.width(W), .uops_w(UW)) bus ();
  pippo_alu_issue #(.width(W), .uops_w(UW)) dut (.clk(clk), .rst(rst), .io(bus));

  function automatic logic [W-1:0] alu(input logic [UW-1:0] u, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    case (u)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_XOR:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  assign bus.alu_result = alu(bus.alu_uops, bus.bus_a, bus.bus_b);

  int           n_vec = 0;
  int           n_err = 0;
  exp_t         exp_q[$];
  exp_t         e_m;
  bit           mf_vld = 1'b0;
  logic [4:0]   mf_rd = '0;
  logic [W-1:0] mf_data = '0;
  bit           rnd_rdy = 1'b0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [UW-1:0] u, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2);
    bit           ok;
    logic [W-1:0] ea, eb, r;
    ok = 1'b0;
    bus.id_valid = 1'b1; bus.id_uops = u; bus.id_opa = a; bus.id_opb = b;
    bus.id_rd = rd; bus.id_rs1 = rs1; bus.id_rs2 = rs2;
    bus.id_use_rs1 = u1; bus.id_use_rs2 = u2;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (rnd_rdy) bus.wb_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      ok = bus.id_ready;
      @(posedge clk);
      #1;
    end
    bus.id_valid = 1'b0;
    if (!ok) chk("push_timeout", 0, 1);
    else begin
      ea = (FWD && u1 && mf_vld && rs1 == mf_rd && rs1 != 5'd0) ? mf_data : a;
      eb = (FWD && u2 && mf_vld && rs2 == mf_rd && rs2 != 5'd0) ? mf_data : b;
      r  = alu(u, ea, eb);
      mf_vld = 1'b1; mf_rd = rd; mf_data = r;
      exp_q.push_back('{rd: rd, res: r});
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("drain_left", 64'(exp_q.size()), 0);
  endtask

  // Writeback monitor: in-order scoreboard plus hold-while-stalled check.
  logic         stall_q = 1'b0;
  logic [W-1:0] res_q = '0;
  logic [4:0]   rd_q = '0;
  always @(negedge clk) begin
    if (rst || bus.flush) begin
      stall_q <= 1'b0;
    end else begin
      if (stall_q) begin
        chk("hold_vld", 64'(bus.wb_valid), 1);
        chk("hold_res", bus.wb_result, res_q);
        chk("hold_rd", 64'(bus.wb_rd), 64'(rd_q));
      end
      if (bus.wb_valid && bus.wb_ready) begin
        if (exp_q.size() == 0) chk("wb_spurious", 1, 0);
        else begin
          e_m = exp_q.pop_front();
          chk("wb_res", bus.wb_result, e_m.res);
          chk("wb_rd", 64'(bus.wb_rd), 64'(e_m.rd));
        end
      end
      stall_q <= bus.wb_valid && !bus.wb_ready;
      res_q   <= bus.wb_result;
      rd_q    <= bus.wb_rd;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.id_valid = 0; bus.id_uops = '0; bus.id_opa = '0; bus.id_opb = '0;
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
    bus.id_rd = '0; bus.flush = 0; bus.wb_ready = 0;

    @(negedge clk);
    chk("rst_vld", 64'(bus.wb_valid), 0);
    chk("rst_res", bus.wb_result, 0);
    chk("rst_rd", 64'(bus.wb_rd), 0);
    chk("rst_rdy", 64'(bus.id_ready), 1);
    chk("rst_uops", 64'(bus.alu_uops), 0);
    chk("rst_busy", 64'(bus.busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single op latency: wb_valid two cycles after the push edge.
    bus.wb_ready = 1'b1;
    push(OP_ADD, 5, 7, 5'd3, 0, 0, 0, 0);
    @(negedge clk);
    chk("lat_c1_vld", 64'(bus.wb_valid), 0);
    @(negedge clk);
    chk("lat_c2_vld", 64'(bus.wb_valid), 1);
    chk("lat_c2_res", bus.wb_result, 12);
    chk("lat_c2_rd", 64'(bus.wb_rd), 3);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_idle_busy", 64'(bus.busy), 0);

    // Backpressure: fill queue behind a stalled result, then release.
    @(posedge clk); #1;
    bus.wb_ready = 1'b0;
    push(OP_ADD, 1, 2, 5'd5, 0, 0, 0, 0);
    push(OP_SUB, 20, 3, 5'd6, 0, 0, 0, 0);
    push(OP_XOR, 64'hF0, 64'h0F, 5'd7, 0, 0, 0, 0);
    @(negedge clk);
    chk("full_rdy", 64'(bus.id_ready), 0);
    chk("full_res", bus.wb_result, 3);
    chk("full_busy", 64'(bus.busy), 1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    bus.wb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("tput_vld", 64'(bus.wb_valid), 1);
    end
    @(posedge clk); #1;

    // Flush with full queue, stalled result and a colliding push.
    bus.wb_ready = 1'b0;
    push(OP_ADD, 10, 10, 5'd8, 0, 0, 0, 0);
    push(OP_ADD, 11, 11, 5'd9, 0, 0, 0, 0);
    push(OP_ADD, 12, 12, 5'd10, 0, 0, 0, 0);
    bus.flush = 1'b1;
    bus.id_valid = 1'b1; bus.id_uops = OP_ADD; bus.id_opa = 64'd99; bus.id_opb = 64'd1;
    bus.id_rd = 5'd11;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.id_valid = 1'b0;
    exp_q.delete();
    mf_vld = 1'b0;
    @(negedge clk);
    chk("flush_vld", 64'(bus.wb_valid), 0);
    chk("flush_busy", 64'(bus.busy), 0);
    chk("flush_rdy", 64'(bus.id_ready), 1);
    chk("flush_uops", 64'(bus.alu_uops), 0);
    @(posedge clk); #1;
    bus.wb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush_gone", 64'(bus.wb_valid), 0);
    end
    @(posedge clk); #1;

    // Forwarding: back-to-back dependent op, x0 source, rs2 path.
    push(OP_ADD, 4, 6, 5'd4, 0, 0, 0, 0);
    push(OP_ADD, 0, 0, 5'd0, 5'd4, 1, 0, 0);
    @(negedge clk);
    chk("fwd_a", bus.bus_a, FWD ? 64'd10 : 64'd0);
    @(posedge clk); #1;
    push(OP_ADD, 0, 1, 5'd9, 5'd0, 1, 0, 0);
    @(negedge clk);
    chk("fwd_a_x0", bus.bus_a, 0);
    @(posedge clk); #1;
    push(OP_ADD, 100, 0, 5'd9, 0, 0, 5'd9, 1);
    @(negedge clk);
    chk("fwd_b", bus.bus_b, FWD ? 64'd1 : 64'd0);
    @(posedge clk); #1;
    drain();

    // Random ops with random writeback backpressure.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 40; i++)
      push(UW'($urandom_range(1, 3)), {$urandom, $urandom}, {$urandom, $urandom},
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    rnd_rdy = 1'b0;
    bus.wb_ready = 1'b1;
    drain();
    chk("drain_busy", 64'(bus.busy), 0);

    // Asynchronous reset between edges with one queued op and one stalled result.
    bus.wb_ready = 1'b0;
    push(OP_ADD, 1, 1, 5'd1, 0, 0, 0, 0);
    push(OP_ADD, 2, 2, 5'd2, 0, 0, 0, 0);
    chk("pre_arst_busy", 64'(bus.busy), 1);
    chk("pre_arst_vld", 64'(bus.wb_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_vld", 64'(bus.wb_valid), 0);
    chk("arst_busy", 64'(bus.busy), 0);
    chk("arst_rdy", 64'(bus.id_ready), 1);
    chk("arst_uops", 64'(bus.alu_uops), 0);
    exp_q.delete();
    mf_vld = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.wb_ready = 1'b1;
    push(OP_SUB, 50, 8, 5'd12, 0, 0, 0, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pippo_alu_issue.md
PIPPO_ALU_ISSUE -- requirements
Module: pippo_alu_issue

Interface
REQ-001 SHALL have parameter: width, default `OPERAND_WIDTH (64), operand/result width.
REQ-002 SHALL have parameter: uops_w, default `ALUUOPS_WIDTH, micro-op width.
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_valid  in  1  decode offers an ALU op.
- id_ready  out  1  issue queue can accept.
- id_uops  in  uops_w  decoded ALU micro-op.
- id_opa / id_opb  in  width  operand values read at decode.
- id_rs1 / id_rs2  in  5  source register indices.
- id_use_rs1 / id_use_rs2  in  1  operand comes from a register (not an immediate).
- id_rd  in  5  destination register index.
- flush  in  1  discard all queued and pending work.
- alu_uops  out  uops_w  to ALU.
- bus_a / bus_b  out  width  to ALU.
- alu_result  in  width  combinational ALU result.
- wb_valid  out  1  result register holds a result.
- wb_ready  in  1  writeback accepts the result.
- wb_result  out  width  registered result.
- wb_rd  out  5  destination of wb_result.
- busy  out  1  queue non-empty or wb_valid high.

Function
REQ-004 SHALL hold a 2-entry FIFO of {uops, opa, opb, rs1, rs2, use_rs1, use_rs2, rd}, with count 0..2.
REQ-005 id_ready SHALL be (count < 2); it SHALL NOT depend combinationally on wb_ready or id_valid.
REQ-006 Push SHALL occur on a rising edge when id_valid and id_ready are both high; id_* are sampled only then.
REQ-007 The head entry SHALL drive alu_uops/bus_a/bus_b combinationally. When the queue is empty, alu_uops SHALL be 0 and bus_a/bus_b SHALL hold the last head values.
REQ-008 Issue (pop) SHALL occur when count>0 and (!wb_valid or wb_ready). On issue: wb_result<=alu_result, wb_rd<=head rd, wb_valid<=1.
REQ-009 When no issue occurs and wb_valid&wb_ready is high, wb_valid SHALL clear to 0.
REQ-010 Latency: an op pushed at the edge ending cycle C, with the queue empty and the output free, SHALL present wb_valid in cycle C+2. Sustained throughput SHALL be 1 op/cycle when wb_ready is held high.
REQ-011 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order. Read/write pointers SHALL wrap modulo 2.
REQ-012 While wb_valid is high and wb_ready is low, wb_result and wb_rd SHALL be held stable.
REQ-013 flush SHALL be synchronous and SHALL dominate push and issue in the same cycle: count<=0, pointers<=0, wb_valid<=0, forwarding valid<=0.
REQ-014 busy SHALL be (count!=0) | wb_valid.

Reset
REQ-015 During rst: count=0, pointers=0, wb_valid=0, wb_result=0, wb_rd=0, forwarding valid=0.
REQ-016 Outputs after reset: id_ready=1, alu_uops=0, busy=0.
REQ-017 Assertion of rst mid-operation SHALL discard all entries immediately, without waiting for a clock edge.

Configuration
REQ-018 Macro PIPPO_ALU_FWD_EN SHALL enable result forwarding.
- Defined: keep fwd_vld (set on each issue, cleared on reset/flush) and fwd_rd/fwd_data (the last issued rd and result).
  - bus_a SHALL equal fwd_data when head use_rs1 & fwd_vld & rs1==fwd_rd & rs1!=0; otherwise bus_a SHALL equal head opa.
  - bus_b SHALL follow the same rule using rs2/opb.
- Undefined: bus_a/bus_b SHALL equal head opa/opb, id_rs1/id_rs2/id_use_rs* SHALL be ignored, and no forwarding state SHALL exist.

Verification
REQ-019 Reset, then a single push (ADD, opa=5, opb=7, rd=3), wb_ready=1 -> wb_valid in cycle C+2 with wb_result=12, wb_rd=3; busy=0 afterwards.
REQ-020 Hold wb_ready=0 and push 3 ops -> id_ready=0 after 2 pushes plus 1 issued (count=2); wb_result is held. Raise wb_ready -> results emerge in order, 1/cycle.
REQ-021 Raise flush in the same cycle as id_valid with count=2 and wb_valid=1 -> next cycle count=0, wb_valid=0, id_ready=1; the pushed op is discarded.
REQ-022 FWD_EN, op1 ADD rd=4 result 10, back-to-back op2 use_rs1, rs1=4, stale opa=0 -> bus_a=10; with rs1=0 -> bus_a=0. Without the macro -> bus_a=0 in both cases.
REQ-023 Assert rst asynchronously between edges with count=1 and wb_valid=1 -> wb_valid and busy fall before the next edge.
